// File: rtl/instr_mem_ctrl_if.sv
// Fetch, response and program-load signals between instr_mem_ctrl and its client.
// The client drives the master modport and the memory controller uses the slave modport.
interface instr_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_rdy;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_ack;
    logic              addr_fault;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (
        output fetch_req, fetch_addr, instr_ack, load_en, load_addr, load_data,
        input  fetch_rdy, instr_valid, instr, addr_fault
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_ack, load_en, load_addr, load_data,
        output fetch_rdy, instr_valid, instr, addr_fault
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction store with per-word loaded flags; unloaded/faulted fetches return NOP_WORD.
// Latency: one cycle from accepted fetch to instr_valid; one response per cycle back-to-back.
// Backpressure: fetch_rdy drops while a response is held unacked or a load is strobed.
// Build option: define INSTR_MEM_FAULT_EN to flag out-of-range or odd fetch addresses.
module instr_mem_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_mem_ctrl_if.slave       bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] instr_q;
    logic              fault_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  loaded;

    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  load_idx;
    logic [ADDR_W-1:0] load_hi;
    logic              load_ok;
    logic              fetch_fault;
    logic              fetch_acc;
    logic              resp_valid;
    logic [DATA_W-1:0] rd_word;

    assign fetch_idx = bus.fetch_addr[IDX_W:1];
    assign load_idx  = bus.load_addr[IDX_W:1];

    // Loads outside the array or on odd bytes are dropped without touching any state.
    assign load_hi = bus.load_addr >> (IDX_W + 1);
    assign load_ok = bus.load_en && !bus.load_addr[0] && (load_hi == '0);

`ifdef INSTR_MEM_FAULT_EN
    logic [ADDR_W-1:0] fetch_hi;
    assign fetch_hi    = bus.fetch_addr >> (IDX_W + 1);
    assign fetch_fault = (fetch_hi != '0) || bus.fetch_addr[0];
`else
    assign fetch_fault = 1'b0;
`endif

    assign resp_valid    = (state == FULL);
    assign bus.fetch_rdy = !bus.load_en && (!resp_valid || bus.instr_ack);
    assign fetch_acc     = bus.fetch_req && bus.fetch_rdy;

    assign rd_word = (!fetch_fault && loaded[fetch_idx]) ? mem[fetch_idx] : NOP_WORD;

    // Data array is left unreset; the cleared loaded flags hide stale contents.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded <= '0;
        end else if (load_ok) begin
            loaded[load_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
        end else if (fetch_acc) begin
            state   <= FULL;
            instr_q <= rd_word;
            fault_q <= fetch_fault;
        end else if (resp_valid && bus.instr_ack) begin
            state   <= EMPTY;
        end
    end

    assign bus.instr_valid = resp_valid;
    assign bus.instr       = instr_q;
    assign bus.addr_fault  = fault_q;
endmodule
